// File: rtl/pidp10_panel_bridge.sv
// rtl/pidp10_panel_bridge.sv - panel-side responder for the PiDP-10 LED/switch scan matrix
module pidp10_panel_bridge #(
  parameter int LED_SKEW     = 1,
  parameter int PULSE_FRAMES = 2,
  parameter int NUM_ROWS     = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row_addr,
  inout  wire  [17:0] col,
  input  logic [2:0]  led_rd_row,
  output logic [17:0] led_rd_data,
  output logic        frame_done,
  output logic [15:0] frame_count,
  input  logic        sw_wr_en,
  input  logic [2:0]  sw_wr_row,
  input  logic [17:0] sw_wr_data,
  output logic        seq_err,
  input  logic        seq_err_clr,
  output logic        synced
);

  localparam logic [4:0] NR5      = 5'(NUM_ROWS);
  localparam logic [4:0] SK5      = 5'(LED_SKEW);
  localparam logic [3:0] LAST_ROW = 4'(NUM_ROWS - 1);
  localparam logic [7:0] PULSE_LD = 8'(PULSE_FRAMES);

  typedef enum logic {HUNT, SYNC} state_t;

  state_t      state_q, state_d;
  logic [3:0]  prev_q, prev_d;
  logic        dirty_q, dirty_d;
  logic [17:0] shadow_q [7];
  logic [17:0] shadow_d [7];
  logic [17:0] committed_q [7];
  logic [17:0] committed_d [7];
  logic [17:0] sw_q [5];
  logic [17:0] sw_d [5];
  logic [7:0]  pulse_q, pulse_d;
  logic [17:0] led_rd_data_q, led_rd_data_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        seq_err_q, seq_err_d;

  logic        sw_row;
  logic [17:0] col_out;
  logic [4:0]  row5, tgt;
  logic [3:0]  exp_row;
  logic        capture_ok;

  // Switch rows drive col; every other row leaves the bus to the scanner.
  always_comb begin
    sw_row  = (row_addr >= 4'd8) && (row_addr <= 4'd12);
    col_out = '0;
    for (int i = 0; i < 5; i++) begin
      if (row_addr[2:0] == 3'(i)) col_out = sw_q[i];
    end
    if (reset) col_out = '0;
  end

  assign col = sw_row ? col_out : 'z;

  always_comb begin
    row5       = {1'b0, row_addr};
    tgt        = row5 + NR5 - SK5;
    if (tgt >= NR5) tgt = tgt - NR5;
    capture_ok = (row5 < NR5) && (tgt < 5'd7);
    exp_row    = (prev_q == LAST_ROW) ? 4'd0 : prev_q + 4'd1;
  end

  always_comb begin
    state_d       = state_q;
    prev_d        = prev_q;
    dirty_d       = dirty_q;
    shadow_d      = shadow_q;
    committed_d   = committed_q;
    sw_d          = sw_q;
    pulse_d       = pulse_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    seq_err_d     = seq_err_clr ? 1'b0 : seq_err_q;
    led_rd_data_d = '0;

    case (state_q)
      HUNT: begin
        if (row_addr == 4'd0) begin
          state_d = SYNC;
          prev_d  = 4'd0;
          dirty_d = 1'b1;
        end
      end
      default: begin
        if ((row5 < NR5) && (row_addr == exp_row)) begin
          prev_d = row_addr;
          if (capture_ok) begin
            for (int i = 0; i < 7; i++) begin
              if (tgt == 5'(i)) shadow_d[i] = ~col;
            end
          end
          // A frame that began mid-stream is never committed; the next one is clean.
          if (row_addr == LAST_ROW) begin
            if (!dirty_q) begin
              committed_d   = shadow_d;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
            end
            dirty_d = 1'b0;
          end
        end else begin
          seq_err_d = 1'b1;
          state_d   = HUNT;
          for (int i = 0; i < 7; i++) shadow_d[i] = '0;
        end
      end
    endcase

    if (frame_done_q && (pulse_q != 8'd0)) begin
      pulse_d = pulse_q - 8'd1;
      if (pulse_q == 8'd1) sw_d[3][9:0] = '0;
    end
    // Host write lands after the decrement so it wins a same-cycle collision.
    if (sw_wr_en) begin
      for (int i = 0; i < 5; i++) begin
        if (sw_wr_row == 3'(i)) sw_d[i] = sw_wr_data;
      end
      if (sw_wr_row == 3'd3) pulse_d = PULSE_LD;
    end

    for (int i = 0; i < 7; i++) begin
      if (led_rd_row == 3'(i)) led_rd_data_d = committed_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= HUNT;
      prev_q        <= '0;
      dirty_q       <= 1'b1;
      shadow_q      <= '{default: '0};
      committed_q   <= '{default: '0};
      sw_q          <= '{default: '0};
      pulse_q       <= '0;
      led_rd_data_q <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      seq_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_q        <= prev_d;
      dirty_q       <= dirty_d;
      shadow_q      <= shadow_d;
      committed_q   <= committed_d;
      sw_q          <= sw_d;
      pulse_q       <= pulse_d;
      led_rd_data_q <= led_rd_data_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign led_rd_data = led_rd_data_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign seq_err     = seq_err_q;
  assign synced      = (state_q == SYNC);

endmodule

// File: tb/tb_pidp10_panel_bridge.sv
// tb/tb_pidp10_panel_bridge.sv - scoreboard bench for pidp10_panel_bridge
module tb_pidp10_panel_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  row_addr;
  wire  [17:0] col;
  logic [2:0]  led_rd_row;
  logic [17:0] led_rd_data;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        sw_wr_en;
  logic [2:0]  sw_wr_row;
  logic [17:0] sw_wr_data;
  logic        seq_err;
  logic        seq_err_clr;
  logic        synced;
  logic        tb_en;
  logic [17:0] tb_val;

  // Pull-ups make a released bus read all ones.
  assign col = tb_en ? tb_val : 'z;
  pullup (col);

  always #5 clk = ~clk;

  pidp10_panel_bridge dut (
    .clk(clk), .reset(reset), .row_addr(row_addr), .col(col),
    .led_rd_row(led_rd_row), .led_rd_data(led_rd_data),
    .frame_done(frame_done), .frame_count(frame_count),
    .sw_wr_en(sw_wr_en), .sw_wr_row(sw_wr_row), .sw_wr_data(sw_wr_data),
    .seq_err(seq_err), .seq_err_clr(seq_err_clr), .synced(synced)
  );

  typedef enum {C_COL, C_LED, C_FC, C_SEQ, C_SYNC, C_FD} sel_t;
  typedef struct { sel_t sel; logic [31:0] exp; } chk_t;
  typedef struct { int cyc; logic [15:0] fc; } fexp_t;

  chk_t  chk_q [$];
  fexp_t fq [$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  logic [15:0] fc_exp;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    chk_t        c;
    fexp_t       f;
    logic [31:0] act;
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      case (c.sel)
        C_COL:   act = 32'(col);
        C_LED:   act = 32'(led_rd_data);
        C_FC:    act = 32'(frame_count);
        C_SEQ:   act = 32'(seq_err);
        C_SYNC:  act = 32'(synced);
        default: act = 32'(frame_done);
      endcase
      checks++;
      if (act !== c.exp) begin
        failures++;
        $display("FAIL %s cyc=%0d actual=%h required=%h", c.sel.name(), cyc, act, c.exp);
      end
    end
    if (fq.size() > 0 && fq[0].cyc < cyc) begin
      f = fq.pop_front();
      checks++;
      failures++;
      $display("FAIL frame_done_missing cyc=%0d actual=none required=cyc%0d", cyc, f.cyc);
    end
    if (frame_done) begin
      checks++;
      if (fq.size() == 0) begin
        failures++;
        $display("FAIL frame_done_unexpected cyc=%0d actual=1 required=0", cyc);
      end else begin
        f = fq.pop_front();
        if (f.cyc != cyc || frame_count !== f.fc) begin
          failures++;
          $display("FAIL frame_done cyc=%0d count=%0d required cyc=%0d count=%0d",
                   cyc, frame_count, f.cyc, f.fc);
        end
      end
    end
  end

  task automatic push(input sel_t s, input logic [31:0] e);
    chk_q.push_back(chk_t'{s, e});
  endtask

  task automatic set_row(input logic [3:0] r);
    row_addr = r;
    if (r >= 4'd1 && r <= 4'd7) begin
      tb_en  = 1'b1;
      tb_val = ~(18'h3F000 + 18'(r - 4'd1));
    end else begin
      tb_en  = 1'b0;
      tb_val = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    sw_wr_en    = 1'b0;
    seq_err_clr = 1'b0;
  endtask

  task automatic check_all_zero();
    push(C_LED, 0); push(C_FC, 0); push(C_SEQ, 0); push(C_SYNC, 0); push(C_FD, 0);
  endtask

  task automatic scan_frame(input bit commit, input logic [17:0] exp_led, input bit wr,
                            input logic [2:0] wrow, input logic [17:0] wdata,
                            input logic [17:0] e10, input logic [17:0] e11);
    for (int r = 0; r < 13; r++) begin
      set_row(4'(r));
      if (r == 0 && wr) begin
        sw_wr_en = 1'b1; sw_wr_row = wrow; sw_wr_data = wdata;
      end
      if (r == 0)  push(C_COL, 32'h3FFFF);
      if (r == 2)  push(C_LED, 32'(exp_led));
      if (r == 5)  push(C_SYNC, 1);
      if (r == 10) push(C_COL, 32'(e10));
      if (r == 11) push(C_COL, 32'(e11));
      if (r == 12 && commit) begin
        fc_exp = fc_exp + 16'd1;
        fq.push_back(fexp_t'{cyc + 1, fc_exp});
      end
      step();
    end
  endtask

  initial begin
    reset = 1'b1; tb_en = 1'b0; tb_val = '0; led_rd_row = 3'd4;
    sw_wr_en = 1'b0; sw_wr_row = '0; sw_wr_data = '0; seq_err_clr = 1'b0;
    fc_exp = '0;
    set_row(4'd9);
    step();
    push(C_COL, 0);
    step();
    reset = 1'b0;
    set_row(4'd13);
    check_all_zero();
    step();

    scan_frame(0, 18'h0,     0, 3'd0, 18'h0, 18'h0, 18'h0);
    scan_frame(1, 18'h0,     0, 3'd0, 18'h0, 18'h0, 18'h0);
    scan_frame(1, 18'h3F004, 0, 3'd0, 18'h0, 18'h0, 18'h0);
    scan_frame(1, 18'h3F004, 1, 3'd2, 18'h2AAAA, 18'h2AAAA, 18'h0);
    scan_frame(1, 18'h3F004, 1, 3'd3, 18'h00201, 18'h2AAAA, 18'h00201);
    scan_frame(1, 18'h3F004, 0, 3'd0, 18'h0, 18'h2AAAA, 18'h00201);
    scan_frame(1, 18'h3F004, 0, 3'd0, 18'h0, 18'h2AAAA, 18'h0);
    scan_frame(1, 18'h3F004, 1, 3'd3, 18'h3FC05, 18'h2AAAA, 18'h3FC05);
    scan_frame(1, 18'h3F004, 0, 3'd0, 18'h0, 18'h2AAAA, 18'h3FC05);
    scan_frame(1, 18'h3F004, 0, 3'd0, 18'h0, 18'h2AAAA, 18'h3FC00);

    for (int r = 0; r < 6; r++) begin set_row(4'(r)); step(); end
    set_row(4'd7);
    step();
    push(C_SEQ, 1); push(C_SYNC, 0);
    for (int r = 8; r < 13; r++) begin
      set_row(4'(r));
      if (r == 10) push(C_COL, 32'h2AAAA);
      if (r == 12) seq_err_clr = 1'b1;
      step();
    end
    push(C_SEQ, 0);

    scan_frame(0, 18'h3F004, 0, 3'd0, 18'h0, 18'h2AAAA, 18'h3FC00);
    scan_frame(1, 18'h3F004, 0, 3'd0, 18'h0, 18'h2AAAA, 18'h3FC00);

    for (int r = 0; r < 4; r++) begin set_row(4'(r)); step(); end
    set_row(4'd14);
    push(C_COL, 32'h3FFFF);
    step();
    push(C_SEQ, 1); push(C_SYNC, 0);
    set_row(4'd13);
    seq_err_clr = 1'b1;
    step();
    push(C_SEQ, 0);
    step();

    scan_frame(0, 18'h3F004, 0, 3'd0, 18'h0, 18'h2AAAA, 18'h3FC00);

    for (int r = 0; r < 6; r++) begin set_row(4'(r)); step(); end
    set_row(4'd6);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    fc_exp = '0;
    check_all_zero();
    for (int r = 7; r < 13; r++) begin
      set_row(4'(r));
      if (r == 10) push(C_COL, 0);
      step();
    end

    scan_frame(0, 18'h0, 0, 3'd0, 18'h0, 18'h0, 18'h0);
    scan_frame(1, 18'h0, 0, 3'd0, 18'h0, 18'h0, 18'h0);
    set_row(4'd0);
    step();
    set_row(4'd1);
    push(C_LED, 32'h3F004);
    push(C_FC, 1);
    step();
    set_row(4'd2);
    step();
    @(negedge clk);
    #1;
    checks++;
    if (fq.size() != 0) begin
      failures++;
      $display("FAIL frame_done_pending actual=%0d required=0", fq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pidp10_panel_bridge.md
Name: pidp10_panel_bridge

Overview:
Panel-side responder for the PiDP-10 console LED/switch matrix. It sits on the far end of the row_addr/col bus from the console scanner.
- Captures the seven LED rows into a double-buffered frame store.
- Drives switch states onto col during switch rows.
- Checks the row sequence and exposes a host-side register port.

Used for remote-panel bridging and as a synthesizable panel model in simulation. It shares clk with the scanner.

Parameters:
LED_SKEW, 1, scan rows between row_addr presentation and valid LED data on col; col captured while row_addr=r is stored as LED row (r-LED_SKEW) mod 13.
PULSE_FRAMES, 2, number of complete frames a momentary switch (switch row 3) stays asserted after a host write.
NUM_ROWS, 13, scan rows per frame (row_addr 0..NUM_ROWS-1).

Ports:
clk  in  1  system clock, shared with scanner
reset  in  1  synchronous, active-high
row_addr  in  4  scanner row index; bit 3 = 1 means switch row
col  inout  18  matrix columns; LEDs active-low from scanner, switches active-high from this block
led_rd_row  in  3  LED row select 0..6
led_rd_data  out  18  committed LED row, active-high (col inverted); 0 for rows 7
frame_done  out  1  one-cycle pulse when a clean frame commits
frame_count  out  16  clean frames committed, wraps at 0xFFFF->0
sw_wr_en  in  1  host switch write strobe
sw_wr_row  in  3  switch row 0..4 (row_addr 8..12); 5..7 ignored
sw_wr_data  in  18  switch bits, 1 = closed
seq_err  out  1  sticky row-sequence error
seq_err_clr  in  1  clears seq_err
synced  out  1  1 while in SYNC state

Behaviour:
- Reset values:
  - led_rd_data, frame_done, frame_count, seq_err, synced all 0.
  - Shadow store, committed store, switch registers and pulse counter all 0.
  - State = HUNT.
- col drive:
  - Combinational from row_addr.
  - row_addr 8..12: col = switch reg[row_addr-8].
  - All other values: col = Z. This includes 13..15 and every row 0..7.
  - Never drives when row_addr[3]=0, so there is no contention.
- Switch registers:
  - sw_wr_en writes sw_wr_data to the selected row next cycle.
  - Write to switch row 3 also loads the pulse counter with PULSE_FRAMES.
  - Each frame_done decrements the counter when nonzero.
  - On transition to 0, switch row 3 bits [9:0] clear; bits [17:10] are untouched.
  - A write in the same cycle as a decrement wins: counter reloads, data replaced.
- State machine:
  - HUNT: ignore capture. On row_addr==0, go to SYNC and start a frame.
  - SYNC: each cycle expected = (prev+1) mod NUM_ROWS.
    - row_addr==expected: LED capture as below.
    - Mismatch or row_addr>=NUM_ROWS: set seq_err, discard the shadow frame, go to HUNT.
- LED capture:
  - Applies only when row_addr in 0..NUM_ROWS-1 and target t=(row_addr-LED_SKEW) mod 13 is in 0..6.
  - Shadow[t] <= ~col, registered.
  - The first frame after entering SYNC has rows with t from the previous frame unfilled. That frame is marked dirty and not committed.
- Commit:
  - On the cycle row_addr==NUM_ROWS-1 is accepted in SYNC, with the frame clean, the cycle after does committed <= shadow, including that row's capture.
  - At the same point: frame_done pulses 1 cycle and frame_count increments.
- led_rd_data: registered, 1-cycle latency from led_rd_row; reflects the committed store only, never a partial frame.
- seq_err: set dominates seq_err_clr in the same cycle.
- Reset mid-frame: immediate HUNT, all stores cleared, col released (Z) combinationally once row_addr is non-switch. A switch row during reset drives 0.

Test Plan:
- Reset, then a scanner model cycling rows 0..12 with LED data row k = 18'h3F000+k (col = ~value, skewed 1 row) for 3 frames. Required: first frame_done at end of 2nd frame; led_rd_row=4 reads 18'h3F004; frame_count=2.
- Host writes sw_wr_row=2 data 18'h2AAAA. Required: col=18'h2AAAA exactly while row_addr=10; col Z in rows 0..7.
- Host writes switch row 3 = 18'h00201, PULSE_FRAMES=2. Required: col=18'h00201 at row 11 for 2 frames; bits[9:0] read 0 after the 2nd frame_done.
- Inject row jump 5->7. Required: seq_err=1, synced=0, no frame_done; committed data unchanged; resync at next row 0 and commit resumes one frame later.
- row_addr=14 in SYNC. Required: seq_err set, col Z; seq_err_clr with no new error clears it next cycle.
- Assert reset at row 6 mid-frame. Required: all outputs 0, HUNT; the partial frame is never committed.
